// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix scan engine.
//   mode_e  : scroll mode encodings carried on mode_i
//   wrap_add: modulo add by compare-and-wrap (operands already < n)
// Column convention: bit 0 of every column vector is the leftmost LED.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_UP     = 2'b11
    } mode_e;

    // (a + b) mod n for a, b < n; avoids a divider for non-power-of-two sizes.
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Row-scan timing for the LED matrix.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   div_clr_i         : clear the frame divider (mode change)
//   row_o             : row currently being dwelt on
//   dwell_blank_o     : dwell counter is inside the anti-ghosting blank window
//   frame_first_o     : first cycle of the frame (row 0, dwell 0)
//   frame_boundary_o  : last cycle of the frame (last row, last dwell cycle)
//   scroll_tick_o     : frame boundary on which the divider wraps
module led_scan_timer #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned ROW_TICKS    = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned SCROLL_DIV   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    div_clr_i,
    output logic [$clog2(ROWS)-1:0] row_o,
    output logic                    dwell_blank_o,
    output logic                    frame_first_o,
    output logic                    frame_boundary_o,
    output logic                    scroll_tick_o
);

    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned TW   = $clog2(ROW_TICKS);
    localparam int unsigned DIVW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [TW-1:0]   dwell_q, dwell_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DIVW-1:0] div_q, div_d;
    logic            dwell_wrap, row_last, div_last;

    always_comb begin
        dwell_wrap       = (dwell_q == TW'(ROW_TICKS - 1));
        row_last         = (row_q == RW'(ROWS - 1));
        div_last         = (div_q == DIVW'(SCROLL_DIV - 1));
        frame_boundary_o = dwell_wrap && row_last;
        scroll_tick_o    = frame_boundary_o && div_last;
        dwell_blank_o    = (dwell_q < TW'(BLANK_CYCLES));
        frame_first_o    = (dwell_q == '0) && (row_q == '0);
        row_o            = row_q;

        dwell_d = dwell_wrap ? '0 : dwell_q + 1'b1;
        row_d   = row_q;
        if (dwell_wrap) begin
            row_d = row_last ? '0 : row_q + 1'b1;
        end
        div_d = div_q;
        if (div_clr_i) begin
            div_d = '0;
        end else if (frame_boundary_o) begin
            div_d = div_last ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dwell_q <= '0;
            row_q   <= '0;
            div_q   <= '0;
        end else begin
            dwell_q <= dwell_d;
            row_q   <= row_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan engine for a ROWS x COLS RGB LED matrix with a double-buffered
// frame store and four scroll modes.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   wr_en_i, wr_row_i, wr_*_i   : write one row into the shadow bank
//   swap_i                      : request a bank swap at the next frame boundary
//   mode_i                      : 00 static, 01 left, 10 right, 11 up
//   led_row_o                   : one-hot row enable (registered)
//   led_col_{r,g,b}_o           : column data for the enabled row (registered)
//   frame_start_o               : pulse aligned with the first output of row 0
//   swap_done_o                 : pulse the cycle after the banks flip
module led_matrix_scan_ctrl #(
    parameter int unsigned ROWS         = 8,
    parameter int unsigned COLS         = 8,
    parameter int unsigned ROW_TICKS    = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned SCROLL_DIV   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [$clog2(ROWS)-1:0] wr_row_i,
    input  logic [COLS-1:0]         wr_r_i,
    input  logic [COLS-1:0]         wr_g_i,
    input  logic [COLS-1:0]         wr_b_i,
    input  logic                    swap_i,
    input  logic [1:0]              mode_i,
    output logic [ROWS-1:0]         led_row_o,
    output logic [COLS-1:0]         led_col_r_o,
    output logic [COLS-1:0]         led_col_g_o,
    output logic [COLS-1:0]         led_col_b_o,
    output logic                    frame_start_o,
    output logic                    swap_done_o
);

    import led_pkg::*;

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    logic [RW-1:0]   row;
    logic            dwell_blank, frame_first, frame_boundary, scroll_tick;

    logic            bank_sel_q, bank_sel_d;   // selects the display bank
    logic            pending_q, pending_d;
    logic            flip, mode_change, wr_ok;
    mode_e           mode_q;
    logic [CW-1:0]   coff_q, coff_d;
    logic [RW-1:0]   roff_q, roff_d;
    logic [RW-1:0]   disp_row;

    logic [ROWS-1:0] led_row_q, led_row_d;
    logic [COLS-1:0] col_r_q, col_r_d, col_g_q, col_g_d, col_b_q, col_b_d;
    logic            frame_start_q, swap_done_q;

    logic [COLS-1:0] bank_r_q [2][ROWS];
    logic [COLS-1:0] bank_g_q [2][ROWS];
    logic [COLS-1:0] bank_b_q [2][ROWS];
    logic [COLS-1:0] disp_r, disp_g, disp_b;

    led_scan_timer #(
        .ROWS        (ROWS),
        .ROW_TICKS   (ROW_TICKS),
        .BLANK_CYCLES(BLANK_CYCLES),
        .SCROLL_DIV  (SCROLL_DIV)
    ) u_timer (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .div_clr_i       (mode_change),
        .row_o           (row),
        .dwell_blank_o   (dwell_blank),
        .frame_first_o   (frame_first),
        .frame_boundary_o(frame_boundary),
        .scroll_tick_o   (scroll_tick)
    );

    // Swap and scroll control.
    always_comb begin
        mode_change = (mode_e'(mode_i) != mode_q);
        flip        = frame_boundary && pending_q;
        bank_sel_d  = bank_sel_q ^ flip;
        // A request arriving in the flip cycle queues the next flip.
        pending_d   = flip ? swap_i : (pending_q || swap_i);

        coff_d = coff_q;
        roff_d = roff_q;
        if (mode_change) begin
            coff_d = '0;
            roff_d = '0;
        end else if (scroll_tick) begin
            case (mode_q)
                MODE_LEFT:  coff_d = (coff_q == CW'(COLS - 1)) ? '0 : coff_q + 1'b1;
                MODE_RIGHT: coff_d = (coff_q == '0) ? CW'(COLS - 1) : coff_q - 1'b1;
                MODE_UP:    roff_d = (roff_q == RW'(ROWS - 1)) ? '0 : roff_q + 1'b1;
                default:    ;
            endcase
        end
    end

    // Output mux: display-bank row chosen by row offset, columns rotated by coff.
    always_comb begin
        wr_ok     = (32'(wr_row_i) < ROWS);
        disp_row  = RW'(wrap_add(32'(row), 32'(roff_q), ROWS));
        disp_r    = bank_r_q[bank_sel_q][disp_row];
        disp_g    = bank_g_q[bank_sel_q][disp_row];
        disp_b    = bank_b_q[bank_sel_q][disp_row];
        led_row_d = '0;
        col_r_d   = '0;
        col_g_d   = '0;
        col_b_d   = '0;
        if (!dwell_blank) begin
            led_row_d = ROWS'(1) << row;
            for (int unsigned c = 0; c < COLS; c++) begin
                col_r_d[c] = disp_r[CW'(wrap_add(c, 32'(coff_q), COLS))];
                col_g_d[c] = disp_g[CW'(wrap_add(c, 32'(coff_q), COLS))];
                col_b_d[c] = disp_b[CW'(wrap_add(c, 32'(coff_q), COLS))];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bank_sel_q    <= 1'b0;
            pending_q     <= 1'b0;
            mode_q        <= MODE_STATIC;
            coff_q        <= '0;
            roff_q        <= '0;
            led_row_q     <= '0;
            col_r_q       <= '0;
            col_g_q       <= '0;
            col_b_q       <= '0;
            frame_start_q <= 1'b0;
            swap_done_q   <= 1'b0;
        end else begin
            bank_sel_q    <= bank_sel_d;
            pending_q     <= pending_d;
            mode_q        <= mode_e'(mode_i);
            coff_q        <= coff_d;
            roff_q        <= roff_d;
            led_row_q     <= led_row_d;
            col_r_q       <= col_r_d;
            col_g_q       <= col_g_d;
            col_b_q       <= col_b_d;
            frame_start_q <= frame_first;
            swap_done_q   <= flip;
        end
    end

    // Writes use the pre-flip select, so a write in the flip cycle lands in
    // the bank that is about to become visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < 2; k++) begin
                for (int unsigned j = 0; j < ROWS; j++) begin
                    bank_r_q[k][j] <= '0;
                    bank_g_q[k][j] <= '0;
                    bank_b_q[k][j] <= '0;
                end
            end
        end else if (wr_en_i && wr_ok) begin
            bank_r_q[~bank_sel_q][wr_row_i] <= wr_r_i;
            bank_g_q[~bank_sel_q][wr_row_i] <= wr_g_i;
            bank_b_q[~bank_sel_q][wr_row_i] <= wr_b_i;
        end
    end

    assign led_row_o     = led_row_q;
    assign led_col_r_o   = col_r_q;
    assign led_col_g_o   = col_g_q;
    assign led_col_b_o   = col_b_q;
    assign frame_start_o = frame_start_q;
    assign swap_done_o   = swap_done_q;

endmodule
